// File: rtl/rf_scoreboard.sv
// -----------------------------------------------------------------------------
// rf_scoreboard
//
// Parametrised register file with a per-register pending-write scoreboard.
// NRD combinational read ports, one write port with write-through bypass.
// Register 0 is hard-wired to zero and is never tracked by the scoreboard.
// The issue stage announces a destination register. The scoreboard counts
// writes that are still in flight to each register, so the hazard unit can
// stall on busy sources without keeping its own bookkeeping.
//
// Optional feature (macro RF_DEBUG_PORT_EN):
//   Adds a raw, non-bypassed debug read port for the board register viewer.
//
// Ports:
//   clk       in   1         clock, all state updates on posedge
//   rst       in   1         asynchronous active-low reset
//   we        in   1         writeback enable
//   wa        in   AW        writeback address
//   wd        in   XLEN      writeback data
//   ra        in   NRD*AW    read addresses, port i at [i*AW +: AW]
//   rd        out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
//   rd_busy   out  NRD       port i's register still has a pending write
//   iss_vld   in   1         issue stage presents destination iss_rd
//   iss_rd    in   AW        destination register of the issuing instruction
//   iss_rdy   out  1         issue may be accepted this cycle
//   busy_vec  out  NREG      bit n = register n has a pending write
//   dbg_sel   in   AW        (RF_DEBUG_PORT_EN only) debug read address
//   dbg_data  out  XLEN      (RF_DEBUG_PORT_EN only) raw register contents
// -----------------------------------------------------------------------------
module rf_scoreboard #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int AW       = $clog2(NREG),
    parameter int NRD      = 2,
    parameter int MAX_PEND = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [AW-1:0]       wa,
    input  logic [XLEN-1:0]     wd,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      rd_busy,
    input  logic                iss_vld,
    input  logic [AW-1:0]       iss_rd,
    output logic                iss_rdy,
    output logic [NREG-1:0]     busy_vec
`ifdef RF_DEBUG_PORT_EN
    ,
    input  logic [AW-1:0]       dbg_sel,
    output logic [XLEN-1:0]     dbg_data
`endif
);

    localparam int CW = $clog2(MAX_PEND + 1);

    logic [XLEN-1:0] rf  [NREG];
    logic [CW-1:0]   cnt [NREG];

    logic            wr_en;
    logic            iss_acc;
    logic [CW-1:0]   iss_cnt;
    logic [NREG-1:0] inc_vec;
    logic [NREG-1:0] dec_vec;

    // Addresses beyond the last register are legal on the bus when NREG is
    // not a power of two; they are never written and always read as zero.
    function automatic logic in_range(input logic [AW-1:0] a);
        return 32'(a) < 32'(NREG);
    endfunction

    assign wr_en = we && (wa != '0) && in_range(wa);

    // Pending count of the register being issued to; out-of-range and x0
    // destinations are never tracked and look empty.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; otherwise a latch is inferred.
    always_comb begin
        iss_cnt = '0;
        if (in_range(iss_rd)) begin
            iss_cnt = cnt[iss_rd];
        end
    end

    // A writeback to the same register in this cycle frees a slot, so a full
    // counter can still take the issue (net change zero).
    assign iss_rdy = (iss_rd == '0)
                  || (iss_cnt < CW'(MAX_PEND))
                  || (we && (wa == iss_rd));
    assign iss_acc = iss_vld && iss_rdy;

    for (genvar n = 0; n < NREG; n++) begin : g_cnt
        if (n == 0) begin : g_zero
            assign inc_vec[n] = 1'b0;
            assign dec_vec[n] = 1'b0;
        end else begin : g_track
            assign inc_vec[n] = iss_acc && (iss_rd == AW'(n));
            // A writeback with nothing pending still updates the data but
            // leaves the counter at zero.
            assign dec_vec[n] = we && (wa == AW'(n)) && (cnt[n] != '0);
        end
        assign busy_vec[n] = (cnt[n] != '0);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    // NOTE: the register array is reset along with the counters because the
    // architecture guarantees all registers read zero out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int n = 0; n < NREG; n++) begin
                rf[n]  <= '0;
                cnt[n] <= '0;
            end
        end else begin
            if (wr_en) begin
                rf[wa] <= wd;
            end
            for (int n = 0; n < NREG; n++) begin
                if (inc_vec[n] && !dec_vec[n]) begin
                    cnt[n] <= cnt[n] + 1'b1;
                end else if (dec_vec[n] && !inc_vec[n]) begin
                    cnt[n] <= cnt[n] - 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic            hit;
        logic [XLEN-1:0] data;

        assign addr = ra[i*AW +: AW];
        assign hit  = we && (wa == addr);

        // Reads are forced to zero while reset is asserted so a stray write
        // request cannot leak through the bypass.
        always_comb begin
            data = '0;
            if (rst && (addr != '0) && in_range(addr)) begin
                data = hit ? wd : rf[addr];
            end
        end

        assign rd[i*XLEN +: XLEN] = data;

        // The last outstanding write landing this cycle is bypassed onto the
        // read data, so the operand is already valid.
        assign rd_busy[i] = in_range(addr) && busy_vec[addr]
                         && !((cnt[addr] == CW'(1)) && hit);
    end

`ifdef RF_DEBUG_PORT_EN
    // Raw storage view for the board register viewer; deliberately no bypass.
    assign dbg_data = ((dbg_sel != '0) && in_range(dbg_sel)) ? rf[dbg_sel] : '0;
`else
    // No debug read path in this build.
`endif

endmodule
